// File: rtl/result_history.sv
// ============================================================================
// Module   : result_history
// Purpose  : Circular history of ALU results feeding the 7-segment decoder,
//            browsed with debounced prev/next/live buttons.
//            Optional macro RESULT_HISTORY_DEDUP_EN drops repeats of newest.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module result_history #(
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int WIDTH           = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         result_in,
  input  logic                     result_valid,
  input  logic                     btn_prev,
  input  logic                     btn_next,
  input  logic                     btn_live,
  output logic [WIDTH-1:0]         disp_value,
  output logic [$clog2(DEPTH)-1:0] disp_offset,
  output logic                     live_mode,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cw-1:0] c_db_last   = c_cw'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_aw:0]   c_depth_cnt = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0]   c_two       = (c_aw + 1)'(2);
  localparam logic [c_aw-1:0] c_off_max   = c_aw'(DEPTH - 1);

  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw:0]    r_count;
  logic [c_aw-1:0]  r_offset;
  logic             r_live;
  logic [WIDTH-1:0] r_disp;

  logic [2:0]       w_raw;
  logic [2:0]       w_press;   // {live, next, prev}
  logic             w_wr_en;
  logic [c_aw-1:0]  w_ptr_n;
  logic [c_aw:0]    w_cnt_n;
  logic [c_aw-1:0]  w_off_n;
  logic             w_live_n;
  logic [c_aw-1:0]  w_rd_idx;
  logic [WIDTH-1:0] w_disp_n;

  assign w_raw = {btn_live, btn_next, btn_prev};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic            r_s1;
      logic            r_s2;
      logic            r_lvl;
      logic            r_lvl_d;
      logic [c_cw-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_lvl   <= 1'b0;
          r_lvl_d <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_s1    <= w_raw[gi];
          r_s2    <= r_s1;
          r_lvl_d <= r_lvl;
          // A new level is taken only after an unbroken run of differing samples.
          if (r_s2 == r_lvl) begin
            r_cnt <= '0;
          end else if (r_cnt == c_db_last) begin
            r_cnt <= '0;
            r_lvl <= r_s2;
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end
      end

      assign w_press[gi] = r_lvl & ~r_lvl_d;
    end
  endgenerate

`ifdef RESULT_HISTORY_DEDUP_EN
  assign w_wr_en = result_valid &&
                   !((r_count != '0) && (result_in == r_buf[r_wr_ptr - c_aw'(1)]));
`else
  assign w_wr_en = result_valid;
`endif

  // Write is applied first; the press then sees the post-write count/offset.
  always_comb begin
    w_ptr_n  = r_wr_ptr;
    w_cnt_n  = r_count;
    w_off_n  = r_offset;
    w_live_n = r_live;
    if (w_wr_en) begin
      w_ptr_n = r_wr_ptr + c_aw'(1);
      if (r_count != c_depth_cnt) w_cnt_n = r_count + (c_aw + 1)'(1);
      if (!r_live && (r_offset != c_off_max)) w_off_n = r_offset + c_aw'(1);
    end
    if (w_press[2]) begin
      w_live_n = 1'b1;
      w_off_n  = '0;
    end else if (w_press[0] ^ w_press[1]) begin
      if (w_press[0]) begin
        if (w_live_n) begin
          if (w_cnt_n >= c_two) begin
            w_live_n = 1'b0;
            w_off_n  = c_aw'(1);
          end
        end else if ({1'b0, w_off_n} < (w_cnt_n - (c_aw + 1)'(1))) begin
          w_off_n = w_off_n + c_aw'(1);
        end
      end else if (!w_live_n) begin
        w_off_n = w_off_n - c_aw'(1);
        if (w_off_n == '0) w_live_n = 1'b1;
      end
    end
  end

  // The slot being written this cycle is bypassed from result_in.
  always_comb begin
    w_rd_idx = w_ptr_n - c_aw'(1) - w_off_n;
    if (w_cnt_n == '0)
      w_disp_n = '0;
    else if (w_wr_en && (w_rd_idx == r_wr_ptr))
      w_disp_n = result_in;
    else
      w_disp_n = r_buf[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_wr_ptr] <= result_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_offset <= '0;
      r_live   <= 1'b1;
      r_disp   <= '0;
    end else begin
      r_wr_ptr <= w_ptr_n;
      r_count  <= w_cnt_n;
      r_offset <= w_off_n;
      r_live   <= w_live_n;
      r_disp   <= w_disp_n;
    end
  end

  assign disp_value  = r_disp;
  assign disp_offset = r_offset;
  assign live_mode   = r_live;
  assign count       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_result_history.sv
// ============================================================================
// Module   : tb_result_history
// Purpose  : Directed plus randomized checks of result_history against a
//            queue-based history model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_result_history;

  localparam int DEPTH = 8;
  localparam int DB    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result_in = '0;
  logic        result_valid = 1'b0;
  logic        btn_prev = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_live = 1'b0;
  logic [31:0] disp_value;
  logic [2:0]  disp_offset;
  logic        live_mode;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  // Model: newest entry at index 0, displayed entry is hist[m_off].
  logic [31:0] hist[$];
  int          m_off  = 0;
  bit          m_live = 1'b1;

  result_history #(.DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .result_in(result_in), .result_valid(result_valid),
    .btn_prev(btn_prev), .btn_next(btn_next), .btn_live(btn_live),
    .disp_value(disp_value), .disp_offset(disp_offset),
    .live_mode(live_mode), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_disp;
    exp_disp = (hist.size() == 0) ? 32'h0 : hist[m_off];
    chk({tag, "_disp"}, disp_value, exp_disp);
    chk({tag, "_off"}, {29'h0, disp_offset}, m_off);
    chk({tag, "_live"}, {31'h0, live_mode}, {31'h0, m_live});
    chk({tag, "_cnt"}, {28'h0, count}, hist.size());
  endtask

  task automatic m_write(input logic [31:0] v);
`ifdef RESULT_HISTORY_DEDUP_EN
    if (hist.size() > 0 && hist[0] == v) return;
`endif
    hist.push_front(v);
    if (hist.size() > DEPTH) void'(hist.pop_back());
    if (!m_live && m_off < DEPTH - 1) m_off++;
  endtask

  task automatic m_press(input bit p, input bit n, input bit l);
    if (l) begin
      m_live = 1'b1;
      m_off  = 0;
    end else if (p && !n) begin
      if (m_live) begin
        if (hist.size() >= 2) begin
          m_live = 1'b0;
          m_off  = 1;
        end
      end else if (m_off < hist.size() - 1) begin
        m_off++;
      end
    end else if (n && !p && !m_live) begin
      m_off--;
      if (m_off == 0) m_live = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    hist.delete();
    m_off  = 0;
    m_live = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] v);
    @(negedge clk);
    result_in    = v;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    m_write(v);
  endtask

  // Hold long enough to pass sync + debounce, then release fully.
  task automatic do_press(input bit p, input bit n, input bit l);
    @(negedge clk);
    btn_prev = p; btn_next = n; btn_live = l;
    repeat (DB + 6) @(negedge clk);
    btn_prev = 1'b0; btn_next = 1'b0; btn_live = 1'b0;
    repeat (DB + 6) @(negedge clk);
    m_press(p, n, l);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    do_reset();
    chk("rst_disp", disp_value, 32'h0);
    chk("rst_cnt", {28'h0, count}, 32'd0);
    chk("rst_live", {31'h0, live_mode}, 32'd1);
    chk("rst_off", {29'h0, disp_offset}, 32'd0);

    do_press(1, 0, 0);
    chk("empty_prev_live", {31'h0, live_mode}, 32'd1);
    check_model("empty_prev");

    do_write(32'h11111111);
    do_write(32'h22222222);
    do_write(32'h33333333);
    chk("wr3_disp", disp_value, 32'h33333333);
    chk("wr3_cnt", {28'h0, count}, 32'd3);

    do_press(1, 0, 0);
    chk("prev1", disp_value, 32'h22222222);
    do_press(1, 0, 0);
    chk("prev2", disp_value, 32'h11111111);
    do_press(1, 0, 0);
    chk("prev3_sat", disp_value, 32'h11111111);
    chk("prev3_off", {29'h0, disp_offset}, 32'd2);
    do_press(0, 1, 0);
    do_press(0, 1, 0);
    chk("next2_disp", disp_value, 32'h33333333);
    chk("next2_live", {31'h0, live_mode}, 32'd1);

    do_press(1, 0, 0);
    do_write(32'h44444444);
    chk("brw_wr_off", {29'h0, disp_offset}, 32'd2);
    chk("brw_wr_disp", disp_value, 32'h22222222);
    do_press(0, 0, 1);
    chk("live_disp", disp_value, 32'h44444444);
    check_model("live");

    for (int i = 1; i <= 10; i++) do_write(i);
    chk("wrap_cnt", {28'h0, count}, 32'd8);
    for (int i = 0; i < 7; i++) do_press(1, 0, 0);
    chk("wrap_oldest", disp_value, 32'h3);
    check_model("wrap");

    @(negedge clk) btn_next = 1'b1;
    repeat (2) @(negedge clk);
    btn_next = 1'b0;
    repeat (DB + 8) @(negedge clk);
    chk("glitch_disp", disp_value, 32'h3);
    check_model("glitch");

    do_press(1, 1, 0);
    chk("prevnext_disp", disp_value, 32'h3);
    do_press(1, 0, 1);
    chk("liveprev_live", {31'h0, live_mode}, 32'd1);
    chk("liveprev_disp", disp_value, 32'hA);

    do_press(1, 0, 0);
    do_reset();
    chk("midrst_disp", disp_value, 32'h0);
    chk("midrst_cnt", {28'h0, count}, 32'd0);
    chk("midrst_live", {31'h0, live_mode}, 32'd1);
    chk("midrst_off", {29'h0, disp_offset}, 32'd0);

    do_write(32'h5);
    do_write(32'h5);
`ifdef RESULT_HISTORY_DEDUP_EN
    chk("dup_cnt", {28'h0, count}, 32'd1);
`else
    chk("dup_cnt", {28'h0, count}, 32'd2);
`endif
    check_model("dup");

    for (int k = 0; k < 120; k++) begin
      int op;
      op = $urandom_range(0, 10);
      case (op)
        0, 1, 2:  do_write($urandom());
        3, 4:     do_write($urandom_range(1, 3));
        5:        do_press(1, 0, 0);
        6:        do_press(0, 1, 0);
        7:        do_press(0, 0, 1);
        8:        do_press(1, 1, 0);
        9:        do_press(0, 1, 1);
        default:  if ($urandom_range(0, 3) == 0) do_reset(); else do_press(1, 0, 0);
      endcase
      check_model($sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
